// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC and the IF/ID pipeline register, and
// halts fetch permanently (until reset) on a misaligned or out-of-window address.
module fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc8,
    output logic        if_id_valid,
    output logic        halt,
    output logic [31:0] fetch_count
);

    // One past the last legal byte address; window bounds use 32-bit unsigned arithmetic.
    localparam logic [31:0] PcLimit = PC_RESET + (32'(IM_WORDS) << 2);

    typedef enum logic [0:0] {
        StFetch,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc8_q, if_id_pc8_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        pc_legal;

    assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q >= PC_RESET) && (pc_q < PcLimit);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc8_d   = if_id_pc8_q;
        if_id_valid_d = if_id_valid_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            StFetch: begin
                // Stall dominates redirect; redirect never flushes (delay slot is latched).
                if (!stall) begin
                    if (pc_legal) begin
                        if_id_instr_d = instr_in;
                        if_id_pc_d    = pc_q;
                        if_id_pc8_d   = pc_q + 32'd8;
                        if_id_valid_d = 1'b1;
                        fetch_count_d = fetch_count_q + 32'd1;
                        pc_d          = redirect ? redirect_target : pc_q + 32'd4;
                    end else begin
                        state_d       = StHalt;
                        if_id_instr_d = 32'h0;
                        if_id_valid_d = 1'b0;
                    end
                end
            end
            StHalt: begin
                if_id_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            pc_q          <= PC_RESET;
            if_id_instr_q <= 32'h0;
            if_id_pc_q    <= 32'h0;
            if_id_pc8_q   <= 32'h0;
            if_id_valid_q <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc8_q   <= if_id_pc8_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc_out      = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc8   = if_id_pc8_q;
    assign if_id_valid = if_id_valid_q;
    assign halt        = (state_q == StHalt);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each driven cycle queues its expected post-edge
// state; a monitor pops and compares after every rising edge.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] instr_in;
    logic [31:0] pc_out, if_id_instr, if_id_pc, if_id_pc8, fetch_count;
    logic        if_id_valid, halt;

    typedef struct {
        int          step;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        chk_ifpc;
        logic [31:0] ifpc;
        logic [31:0] ifpc8;
        logic        valid;
        logic        halt;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory model: tag word with the low half of the address.
    assign instr_in = {16'hC0DE, pc_out[15:0]};

    fetch_ctrl #(
        .PC_RESET(32'h0000_3000),
        .IM_WORDS(4096)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .instr_in       (instr_in),
        .pc_out         (pc_out),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc8      (if_id_pc8),
        .if_id_valid    (if_id_valid),
        .halt           (halt),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string name, input int stp, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, stp, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next rising edge.
    task automatic cyc(input logic rst, input logic stl, input logic rdr, input logic [31:0] tgt,
                       input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic e_chk_ifpc, input logic [31:0] e_ifpc,
                       input logic [31:0] e_ifpc8, input logic e_valid, input logic e_halt,
                       input logic [31:0] e_count);
        exp_t e;
        @(negedge clk);
        reset           = rst;
        stall           = stl;
        redirect        = rdr;
        redirect_target = tgt;
        step_no++;
        e.step     = step_no;
        e.pc       = e_pc;
        e.instr    = e_instr;
        e.chk_ifpc = e_chk_ifpc;
        e.ifpc     = e_ifpc;
        e.ifpc8    = e_ifpc8;
        e.valid    = e_valid;
        e.halt     = e_halt;
        e.count    = e_count;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_out", e.step, pc_out, e.pc);
                chk("if_id_instr", e.step, if_id_instr, e.instr);
                if (e.chk_ifpc) begin
                    chk("if_id_pc", e.step, if_id_pc, e.ifpc);
                    chk("if_id_pc8", e.step, if_id_pc8, e.ifpc8);
                end
                chk("if_id_valid", e.step, 32'(if_id_valid), 32'(e.valid));
                chk("halt", e.step, 32'(halt), 32'(e.halt));
                chk("fetch_count", e.step, fetch_count, e.count);
            end
        end
    end

    initial begin : stimulus
        //   rst stl rdr target          pc            instr          ck ifpc          ifpc8         v  h  count
        cyc(1, 0, 0, 32'h0,        32'h3000, 32'h0,         1, 32'h0,    32'h0,    0, 0, 0);
        // Sequential fetch
        cyc(0, 0, 0, 32'h0,        32'h3004, 32'hC0DE3000,  1, 32'h3000, 32'h3008, 1, 0, 1);
        cyc(0, 0, 0, 32'h0,        32'h3008, 32'hC0DE3004,  1, 32'h3004, 32'h300C, 1, 0, 2);
        cyc(0, 0, 0, 32'h0,        32'h300C, 32'hC0DE3008,  1, 32'h3008, 32'h3010, 1, 0, 3);
        // Stall hold at pc 3004
        cyc(1, 0, 0, 32'h0,        32'h3000, 32'h0,         1, 32'h0,    32'h0,    0, 0, 0);
        cyc(0, 0, 0, 32'h0,        32'h3004, 32'hC0DE3000,  1, 32'h3000, 32'h3008, 1, 0, 1);
        cyc(0, 1, 0, 32'h0,        32'h3004, 32'hC0DE3000,  1, 32'h3000, 32'h3008, 1, 0, 1);
        cyc(0, 1, 0, 32'h0,        32'h3004, 32'hC0DE3000,  1, 32'h3000, 32'h3008, 1, 0, 1);
        cyc(0, 0, 0, 32'h0,        32'h3008, 32'hC0DE3004,  1, 32'h3004, 32'h300C, 1, 0, 2);
        // Redirect with delay slot
        cyc(0, 0, 1, 32'h3100,     32'h3100, 32'hC0DE3008,  1, 32'h3008, 32'h3010, 1, 0, 3);
        cyc(0, 0, 0, 32'h0,        32'h3104, 32'hC0DE3100,  1, 32'h3100, 32'h3108, 1, 0, 4);
        // Stall dominates redirect
        cyc(0, 1, 1, 32'h3200,     32'h3104, 32'hC0DE3100,  1, 32'h3100, 32'h3108, 1, 0, 4);
        cyc(0, 0, 0, 32'h0,        32'h3108, 32'hC0DE3104,  1, 32'h3104, 32'h310C, 1, 0, 5);
        // Last legal word, then one past the window
        cyc(0, 0, 1, 32'h6FFC,     32'h6FFC, 32'hC0DE3108,  1, 32'h3108, 32'h3110, 1, 0, 6);
        cyc(0, 0, 1, 32'h7000,     32'h7000, 32'hC0DE6FFC,  1, 32'h6FFC, 32'h7004, 1, 0, 7);
        cyc(0, 0, 0, 32'h0,        32'h7000, 32'h0,         0, 32'h0,    32'h0,    0, 1, 7);
        // HALT ignores redirect and stall
        cyc(0, 0, 1, 32'h3000,     32'h7000, 32'h0,         0, 32'h0,    32'h0,    0, 1, 7);
        cyc(0, 1, 0, 32'h0,        32'h7000, 32'h0,         0, 32'h0,    32'h0,    0, 1, 7);
        // Reset out of HALT, fetch resumes at base
        cyc(1, 0, 0, 32'h0,        32'h3000, 32'h0,         1, 32'h0,    32'h0,    0, 0, 0);
        cyc(0, 0, 0, 32'h0,        32'h3004, 32'hC0DE3000,  1, 32'h3000, 32'h3008, 1, 0, 1);
        // Misaligned target halts
        cyc(0, 0, 1, 32'h3002,     32'h3002, 32'hC0DE3004,  1, 32'h3004, 32'h300C, 1, 0, 2);
        cyc(0, 0, 0, 32'h0,        32'h3002, 32'h0,         0, 32'h0,    32'h0,    0, 1, 2);
        // Below-base target halts; reset while stalled in HALT
        cyc(1, 1, 0, 32'h0,        32'h3000, 32'h0,         1, 32'h0,    32'h0,    0, 0, 0);
        cyc(0, 0, 1, 32'h2FFC,     32'h2FFC, 32'hC0DE3000,  1, 32'h3000, 32'h3008, 1, 0, 1);
        cyc(0, 1, 0, 32'h0,        32'h2FFC, 32'hC0DE3000,  1, 32'h3000, 32'h3008, 1, 0, 1);
        cyc(0, 0, 0, 32'h0,        32'h2FFC, 32'h0,         0, 32'h0,    32'h0,    0, 1, 1);
        // Reset asserted mid-stall from FETCH
        cyc(1, 0, 0, 32'h0,        32'h3000, 32'h0,         1, 32'h0,    32'h0,    0, 0, 0);
        cyc(0, 0, 0, 32'h0,        32'h3004, 32'hC0DE3000,  1, 32'h3000, 32'h3008, 1, 0, 1);
        cyc(1, 1, 1, 32'h5000,     32'h3000, 32'h0,         1, 32'h0,    32'h0,    0, 0, 0);
        cyc(0, 0, 0, 32'h0,        32'h3004, 32'hC0DE3000,  1, 32'h3000, 32'h3008, 1, 0, 1);

        @(negedge clk);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        // Every queued expectation must have been consumed by the monitor.
        chk("scoreboard_drain", step_no, 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        stim_done = 1'b1;
        $finish;
    end

    initial begin : watchdog
        #100000;
        if (!stim_done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog expired");
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The module SHALL have parameter PC_RESET, default 32'h0000_3000, meaning the first fetch address and the base of the instruction memory window.
REQ-002 The module SHALL have parameter IM_WORDS, default 4096, meaning the instruction memory depth in 32-bit words.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port stall, input, 1 bit: hazard unit request to freeze the PC and the IF/ID register.
REQ-006 The module SHALL have port redirect, input, 1 bit: branch taken or jump resolved in D.
REQ-007 The module SHALL have port redirect_target, input, 32 bits: next fetch address when redirect is taken.
REQ-008 The module SHALL have port instr_in, input, 32 bits: instruction word returned combinationally by the instruction memory for pc_out.
REQ-009 The module SHALL have port pc_out, output, 32 bits: current fetch address driven to the instruction memory.
REQ-010 The module SHALL have ports if_id_instr, if_id_pc and if_id_pc8, outputs, 32 bits each: the IF/ID register contents (instruction, its PC, its PC+8).
REQ-011 The module SHALL have port if_id_valid, output, 1 bit: the IF/ID register holds a real fetched instruction.
REQ-012 The module SHALL have port halt, output, 1 bit: fetch stopped on a bad address.
REQ-013 The module SHALL have port fetch_count, output, 32 bits: number of instructions latched into IF/ID since reset.

Function
REQ-014 The module SHALL implement the states FETCH and HALT.
REQ-015 In FETCH, a fetch address SHALL be legal iff pc_out[1:0]==0 and PC_RESET <= pc_out < PC_RESET+4*IM_WORDS, using 32-bit unsigned compare.
REQ-016 In FETCH with stall=1, the PC, the IF/ID register, fetch_count and the state SHALL hold, and redirect SHALL be ignored (stall dominates).
REQ-017 In FETCH with stall=0 and a legal pc_out, the IF/ID register SHALL load {instr_in, pc_out, pc_out+8}, if_id_valid SHALL become 1, and fetch_count SHALL increment by 1, wrapping modulo 2^32.
REQ-018 In the same case, the next PC SHALL be redirect_target if redirect=1, else pc_out+4 (mod 2^32), giving 1-cycle redirect latency.
REQ-019 Redirect SHALL NOT flush IF/ID: the instruction fetched in the redirect cycle is the delay slot and SHALL be latched normally.
REQ-020 In FETCH with stall=0 and an illegal pc_out, the state SHALL go to HALT, if_id_valid SHALL become 0, if_id_instr SHALL become 32'h0 (nop), and the PC and fetch_count SHALL hold.
REQ-021 In HALT, halt SHALL be 1, if_id_valid SHALL stay 0, and the PC and counters SHALL hold regardless of stall and redirect; only reset exits HALT.
REQ-022 halt SHALL be 1 exactly when the state is HALT.
REQ-023 A redirect to an illegal target SHALL be accepted; the halt is taken on the following unstalled cycle per REQ-020.
REQ-024 pc_out SHALL be a direct register output with no combinational path from any input.

Reset
REQ-025 When reset=1 at a rising edge, the following SHALL apply regardless of all other inputs and the current state: state=FETCH, pc_out=PC_RESET, if_id_instr=0, if_id_pc=0, if_id_pc8=0, if_id_valid=0, halt=0, fetch_count=0.
REQ-026 The first fetch SHALL occur in the first cycle with reset=0.
REQ-027 Reset asserted mid-stall or in HALT SHALL have the same effect as reset from power-up.

Verification
REQ-028 The bench SHALL cover sequential fetch: after reset, 3 cycles with stall=0 and redirect=0 -> pc_out steps 3000, 3004, 3008, 300C; if_id_pc=3008, if_id_pc8=3010, fetch_count=3.
REQ-029 The bench SHALL cover stall hold: stall=1 for 2 cycles at pc_out=3004 -> pc_out, if_id_* and fetch_count are unchanged; on release, if_id_pc=3004.
REQ-030 The bench SHALL cover redirect with delay slot: at pc_out=3008, redirect=1 and redirect_target=3100 -> if_id_pc=3008 and the next pc_out=3100.
REQ-031 The bench SHALL cover stall plus redirect: stall=1, redirect=1, target=3200 -> pc_out holds; then stall=0, redirect=0 -> pc_out advances by 4, not to 3200.
REQ-032 The bench SHALL cover the halt path: redirect to 7000 (IM_WORDS=4096) -> next cycle halt=1, if_id_valid=0, if_id_instr=0, and pc_out stays 7000; a misaligned target 3002 also halts.
REQ-033 The bench SHALL cover reset out of HALT: reset=1 for 1 cycle -> halt=0, pc_out=3000, fetch_count=0, and fetch resumes at 3000.
